racket_control: RTL and testbench
=================================

# racket_control

Generates racket positions and the serve strobe for the pong game from player buttons, and drives the second racket automatically in single-player mode. It sits between the debounced-pad inputs and the ball FSM, driving that FSM's `pos_of_player_1`, `pos_of_player_2` and `serve` inputs. It reads back `y_pos_of_ball` so the computer opponent can track the ball.

## Interface

Parameters:

- `RACKET_SPEED`, 6 – pixels moved per frame by a human racket.
- `AI_SPEED`, 4 – pixels moved per frame by the computer racket.
- `Y_TOP`, 51 – top playfield limit for the racket top edge.
- `Y_BOTTOM`, 717 – bottom playfield limit.
- `RACKET_H`, 80 – racket height; the maximum position is `Y_BOTTOM-RACKET_H` = 637.
- `BALL_SIZE`, 15 – ball edge length, used for AI centring.
- `DEBOUNCE_CYCLES`, 65000 – stable cycles required before a button is accepted (1 ms at 65 MHz).

Ports:

- `rst` in 1 – reset, synchronous, active-high.
- `clk65MHz` in 1 – clock, 65 MHz.
- `end_of_frame` in 1 – one-cycle pulse per video frame.
- `btn_up_1`, `btn_down_1`, `btn_up_2`, `btn_down_2`, `btn_serve` in 1 each – raw asynchronous pad inputs, active-high.
- `screen_idle` in 1 – menu screen active.
- `screen_multi` in 1 – 1 = two human players, 0 = player 2 is the computer.
- `y_pos_of_ball` in 11 – current ball top edge.
- `pos_of_player_1` out 10 – racket 1 top edge; reset value 344.
- `pos_of_player_2` out 10 – racket 2 top edge; reset value 344.
- `serve` out 1 – one-cycle serve strobe; reset value 0.

## Operation

Input conditioning:

- Each of the 5 buttons passes through a 2-FF synchronizer.
- A per-button counter follows, sized for `DEBOUNCE_CYCLES`.
- The debounced level toggles only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- Any mismatch gap resets that button's counter.

Human racket movement (player 1 always; player 2 only when `screen_multi`=1):

- Movement updates only on cycles where `end_of_frame`=1.
- up=1, down=0: position = max(pos−`RACKET_SPEED`, `Y_TOP`).
- down=1, up=0: position = min(pos+`RACKET_SPEED`, 637).
- Both buttons or neither: position holds.
- Arithmetic is done in 11 bits. The clamp test (`pos < Y_TOP+speed`) is evaluated before subtracting, so no underflow or wrap occurs.

Computer racket (player 2 when `screen_multi`=0):

- Target = `y_pos_of_ball` + `BALL_SIZE`/2 − `RACKET_H`/2 = ball_y + 7 − 40, computed in 12-bit signed.
- The target is clamped to [51, 637].
- On `end_of_frame`, let diff = target − pos:
  - diff ≥ `AI_SPEED`: pos += `AI_SPEED`.
  - diff ≤ −`AI_SPEED`: pos −= `AI_SPEED`.
  - Otherwise: hold.
- Player 2 buttons are ignored in this mode.

Serve FSM (on debounced `btn_serve`):

- WAIT_RELEASE: stays until serve=0, then goes to ARMED. This is the reset state.
- ARMED: on serve=1, goes to FIRE.
- FIRE: `serve` output=1 for this single cycle, then goes unconditionally to WAIT_RELEASE.
- `serve` is a registered decode of the FIRE state.

Idle screen (`screen_idle`=1), which has priority over all other behaviour:

- Both positions are loaded with 344 on the next edge.
- The serve FSM is forced to WAIT_RELEASE and `serve`=0.
- Debouncers keep running.

Mode switch: a change of `screen_multi` mid-game keeps the current positions. Control source changes at the next `end_of_frame`.

## Timing

- Button edge to debounced level: 2 + `DEBOUNCE_CYCLES` cycles.
- Debounced press to `serve` high: 2 cycles (ARMED→FIRE edge, then output register). `serve` stays high for exactly 1 cycle.
- A serve press already held at reset or idle exit produces no pulse until it is released and pressed again.
- Position outputs change on the edge after the `end_of_frame` cycle, at most once per frame, and are otherwise stable.
- `end_of_frame` coincident with `screen_idle`=1: the idle load of 344 wins.
- `rst` mid-operation returns all outputs to their reset values on the next edge and clears the debouncers to 0.

## Test plan

Benches override `DEBOUNCE_CYCLES`=4.

- Reset release -> `pos_of_player_1`=`pos_of_player_2`=344 and `serve`=0. Outputs stay constant with no `end_of_frame`.
- Multi mode, `btn_up_1` held for 60 frames -> pos1 goes 338, 332, …, 56 after frame 48, 51 at frame 49, and stays at 51. Repeat with `btn_down_1` -> 632 after frame 48, then 637 and stays.
- Both `btn_up_2` and `btn_down_2` held for 10 frames -> pos2 stays 344. A 3-cycle glitch on `btn_up_1` -> no movement.
- Single mode, `y_pos_of_ball`=600 held -> pos2 rises by 4 per frame to 564 (diff 3), then holds. Then `y_pos_of_ball`=0 -> target clamps to 51 and pos2 descends to 52, then holds. Player 2 buttons have no effect throughout.
- `btn_serve` held for 100 cycles -> exactly one `serve` pulse, 1 cycle wide, 2+4+2 cycles after the press. Release and press again -> a second pulse.
- Press `btn_serve` with `screen_idle`=1 -> no pulse, and both positions return to 344. Drop `screen_idle` while serve is still held -> no pulse until release and re-press. Assert `rst` mid-movement -> pos=344 on the next edge.

Source files
------------

// File: rtl/racket_control.sv
// racket_control: racket positions and serve strobe for the pong game.
// Conditions the five button pads (sync + debounce), moves the human rackets
// once per frame, steers racket 2 toward the ball in single-player mode, and
// produces a one-cycle serve strobe per debounced serve press.
module racket_control #(
    parameter int RACKET_SPEED    = 6,
    parameter int AI_SPEED        = 4,
    parameter int Y_TOP           = 51,
    parameter int Y_BOTTOM        = 717,
    parameter int RACKET_H        = 80,
    parameter int BALL_SIZE       = 15,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic        rst,
    input  logic        clk65MHz,
    input  logic        end_of_frame,
    input  logic        btn_up_1,
    input  logic        btn_down_1,
    input  logic        btn_up_2,
    input  logic        btn_down_2,
    input  logic        btn_serve,
    input  logic        screen_idle,
    input  logic        screen_multi,
    input  logic [10:0] y_pos_of_ball,
    output logic [9:0]  pos_of_player_1,
    output logic [9:0]  pos_of_player_2,
    output logic        serve
);

    localparam int POS_MAX    = Y_BOTTOM - RACKET_H;
    localparam int POS_CENTRE = (Y_TOP + POS_MAX) / 2;
    localparam int CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int NUM_BTN    = 5;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]       RESET_POS = 10'(POS_CENTRE);
    localparam logic [10:0]      TOP11     = 11'(Y_TOP);
    localparam logic [10:0]      MAX11     = 11'(POS_MAX);
    localparam logic [10:0]      HSPD11    = 11'(RACKET_SPEED);

    localparam logic signed [11:0] S_TOP  = 12'(Y_TOP);
    localparam logic signed [11:0] S_MAX  = 12'(POS_MAX);
    localparam logic signed [11:0] S_AI   = 12'(AI_SPEED);
    localparam logic signed [11:0] AI_OFS = 12'(BALL_SIZE / 2 - RACKET_H / 2);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_meta;
    logic [NUM_BTN-1:0] btn_sync;
    logic [NUM_BTN-1:0] btn_db;
    logic [CNT_W-1:0]   db_cnt [NUM_BTN];

    assign btn_raw = {btn_serve, btn_down_2, btn_up_2, btn_down_1, btn_up_1};

    // Two-flop synchronizer for the asynchronous pads
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: flip a level only after DEBOUNCE_CYCLES consecutive mismatches
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            btn_db <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (btn_sync[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    btn_db[i] <= ~btn_db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic up_1, down_1, up_2, down_2, serve_btn;
    assign up_1      = btn_db[0];
    assign down_1    = btn_db[1];
    assign up_2      = btn_db[2];
    assign down_2    = btn_db[3];
    assign serve_btn = btn_db[4];

    // ------------------------------------------------------------------
    // Racket movement
    // ------------------------------------------------------------------
    // Clamp is tested before the subtract so the 11-bit result never wraps.
    function automatic logic [9:0] human_step(input logic [9:0] pos,
                                              input logic up,
                                              input logic dn);
        logic [10:0] p;
        p = {1'b0, pos};
        if (up && !dn) begin
            if (p < TOP11 + HSPD11) return TOP11[9:0];
            else                    return 10'(p - HSPD11);
        end else if (dn && !up) begin
            if (p > MAX11 - HSPD11) return MAX11[9:0];
            else                    return 10'(p + HSPD11);
        end
        return pos;
    endfunction

    logic signed [11:0] ai_target_raw;
    logic signed [11:0] ai_target;
    logic signed [11:0] ai_diff;
    logic [9:0]         ai_next;

    // Computer racket: centre on the ball, clamp, then step toward the target
    always_comb begin
        ai_target_raw = $signed({1'b0, y_pos_of_ball}) + AI_OFS;
        ai_target     = ai_target_raw;
        if (ai_target_raw < S_TOP)      ai_target = S_TOP;
        else if (ai_target_raw > S_MAX) ai_target = S_MAX;
        ai_diff = ai_target - $signed({2'b00, pos_of_player_2});
        ai_next = pos_of_player_2;
        if (ai_diff >= S_AI)       ai_next = pos_of_player_2 + 10'(AI_SPEED);
        else if (ai_diff <= -S_AI) ai_next = pos_of_player_2 - 10'(AI_SPEED);
    end

    // Position registers: idle load wins over frame movement
    always_ff @(posedge clk65MHz) begin
        if (rst || screen_idle) begin
            pos_of_player_1 <= RESET_POS;
            pos_of_player_2 <= RESET_POS;
        end else if (end_of_frame) begin
            pos_of_player_1 <= human_step(pos_of_player_1, up_1, down_1);
            if (screen_multi) pos_of_player_2 <= human_step(pos_of_player_2, up_2, down_2);
            else              pos_of_player_2 <= ai_next;
        end
    end

    // ------------------------------------------------------------------
    // Serve FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        ARMED        = 2'd1,
        FIRE         = 2'd2
    } serve_state_t;

    serve_state_t state, state_next;
    logic         serve_next;

    // Serve state register
    always_ff @(posedge clk65MHz) begin
        if (rst) state <= WAIT_RELEASE;
        else     state <= state_next;
    end

    // Serve next-state and strobe decode; idle forces the wait-for-release state
    always_comb begin
        state_next = state;
        serve_next = 1'b0;
        case (state)
            WAIT_RELEASE: if (!serve_btn) state_next = ARMED;
            ARMED:        if (serve_btn)  state_next = FIRE;
            FIRE: begin
                state_next = WAIT_RELEASE;
                serve_next = 1'b1;
            end
            default:      state_next = WAIT_RELEASE;
        endcase
        if (screen_idle) begin
            state_next = WAIT_RELEASE;
            serve_next = 1'b0;
        end
    end

    // Registered serve strobe
    always_ff @(posedge clk65MHz) begin
        if (rst) serve <= 1'b0;
        else     serve <= serve_next;
    end

endmodule

// File: tb/tb_racket_control.sv
// Self-checking bench for racket_control with a short debounce window.
module tb_racket_control;

    localparam int DEB      = 4;
    localparam int SPD      = 6;
    localparam int AI_SPD   = 4;
    localparam int TOP      = 51;
    localparam int BOT      = 637;
    localparam int CENTRE   = 344;
    localparam int SERVE_LAT = 2 + DEB + 2;

    logic        rst, clk, eof;
    logic        up1, dn1, up2, dn2, srv_btn;
    logic        idle, multi;
    logic [10:0] ball;
    logic [9:0]  pos1, pos2;
    logic        serve;

    int checks = 0;
    int errors = 0;
    int m_pos1 = CENTRE;
    int m_pos2 = CENTRE;

    racket_control #(.DEBOUNCE_CYCLES(DEB)) dut (
        .rst             (rst),
        .clk65MHz        (clk),
        .end_of_frame    (eof),
        .btn_up_1        (up1),
        .btn_down_1      (dn1),
        .btn_up_2        (up2),
        .btn_down_2      (dn2),
        .btn_serve       (srv_btn),
        .screen_idle     (idle),
        .screen_multi    (multi),
        .y_pos_of_ball   (ball),
        .pos_of_player_1 (pos1),
        .pos_of_player_2 (pos2),
        .serve           (serve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference rules, expressed as plain integer min/max arithmetic
    function automatic int human_model(int pos, bit up, bit dn);
        if (up && !dn) return (pos - SPD < TOP) ? TOP : pos - SPD;
        if (dn && !up) return (pos + SPD > BOT) ? BOT : pos + SPD;
        return pos;
    endfunction

    function automatic int ai_model(int pos, int by);
        int target, d;
        target = by + 15 / 2 - 80 / 2;
        if (target < TOP) target = TOP;
        if (target > BOT) target = BOT;
        d = target - pos;
        if (d >= AI_SPD)  return pos + AI_SPD;
        if (d <= -AI_SPD) return pos - AI_SPD;
        return pos;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame();
        eof = 1'b1;
        tick();
        eof = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        tick();
        m_pos1 = CENTRE;
        m_pos2 = CENTRE;
        checks++;
        if (pos1 !== 10'(CENTRE)) begin errors++; $display("FAIL reset_pos1: got %0d expected %0d", pos1, CENTRE); end
        checks++;
        if (pos2 !== 10'(CENTRE)) begin errors++; $display("FAIL reset_pos2: got %0d expected %0d", pos2, CENTRE); end
        checks++;
        if (serve !== 1'b0) begin errors++; $display("FAIL reset_serve: got %0b expected 0", serve); end
        up1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (pos1 !== 10'(CENTRE) || pos2 !== 10'(CENTRE)) begin
                errors++;
                $display("FAIL no_frame_hold cycle %0d: got %0d/%0d expected %0d/%0d", i, pos1, pos2, CENTRE, CENTRE);
            end
        end
        up1 = 1'b0;
        ticks(10);
    endtask

    task automatic run_human_dir(input bit go_up);
        up1 = go_up;
        dn1 = !go_up;
        ticks(10);
        for (int f = 1; f <= 60; f++) begin
            frame();
            m_pos1 = human_model(m_pos1, go_up, !go_up);
            checks++;
            if (pos1 !== 10'(m_pos1)) begin
                errors++;
                $display("FAIL human_pos1 dir_up=%0b frame %0d: got %0d expected %0d", go_up, f, pos1, m_pos1);
            end
            if (f == 48) begin
                checks++;
                if (pos1 !== (go_up ? 10'd56 : 10'd632)) begin
                    errors++;
                    $display("FAIL human_frame48 dir_up=%0b: got %0d expected %0d", go_up, pos1, go_up ? 56 : 632);
                end
            end
            if (f == 49) begin
                checks++;
                if (pos1 !== (go_up ? 10'd51 : 10'd637)) begin
                    errors++;
                    $display("FAIL human_clamp dir_up=%0b: got %0d expected %0d", go_up, pos1, go_up ? 51 : 637);
                end
            end
        end
        checks++;
        if (pos2 !== 10'(m_pos2)) begin errors++; $display("FAIL human_pos2_still: got %0d expected %0d", pos2, m_pos2); end
        up1 = 1'b0;
        dn1 = 1'b0;
        idle = 1'b1;
        tick();
        idle = 1'b0;
        m_pos1 = CENTRE;
        m_pos2 = CENTRE;
        checks++;
        if (pos1 !== 10'(CENTRE)) begin errors++; $display("FAIL idle_restore: got %0d expected %0d", pos1, CENTRE); end
        ticks(10);
    endtask

    task automatic test_human();
        multi = 1'b1;
        run_human_dir(1'b1);
        run_human_dir(1'b0);
    endtask

    task automatic test_both_and_glitch();
        up2 = 1'b1;
        dn2 = 1'b1;
        ticks(10);
        for (int f = 0; f < 10; f++) begin
            frame();
            checks++;
            if (pos2 !== 10'(CENTRE)) begin errors++; $display("FAIL both_btn_pos2 frame %0d: got %0d expected %0d", f, pos2, CENTRE); end
        end
        up2 = 1'b0;
        dn2 = 1'b0;
        ticks(10);
        up1 = 1'b1;
        ticks(DEB - 1);
        up1 = 1'b0;
        for (int f = 0; f < 8; f++) begin
            frame();
            checks++;
            if (pos1 !== 10'(m_pos1)) begin errors++; $display("FAIL glitch_pos1 frame %0d: got %0d expected %0d", f, pos1, m_pos1); end
            tick();
        end
    endtask

    task automatic test_ai();
        multi = 1'b0;
        ball = 11'd600;
        for (int f = 0; f < 70; f++) begin
            up2 = 1'($urandom);
            dn2 = 1'($urandom);
            frame();
            m_pos2 = ai_model(m_pos2, 600);
            checks++;
            if (pos2 !== 10'(m_pos2)) begin errors++; $display("FAIL ai_rise frame %0d: got %0d expected %0d", f, pos2, m_pos2); end
        end
        checks++;
        if (pos2 !== 10'd564) begin errors++; $display("FAIL ai_settle_high: got %0d expected 564", pos2); end
        ball = 11'd0;
        for (int f = 0; f < 140; f++) begin
            up2 = 1'($urandom);
            dn2 = 1'($urandom);
            frame();
            m_pos2 = ai_model(m_pos2, 0);
            checks++;
            if (pos2 !== 10'(m_pos2)) begin errors++; $display("FAIL ai_fall frame %0d: got %0d expected %0d", f, pos2, m_pos2); end
        end
        checks++;
        if (pos2 !== 10'd52) begin errors++; $display("FAIL ai_settle_low: got %0d expected 52", pos2); end
        up2 = 1'b0;
        dn2 = 1'b0;
        ticks(10);
    endtask

    task automatic serve_window(input string name, input int n);
        int first, highs;
        first = -1;
        highs = 0;
        srv_btn = 1'b1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (serve === 1'b1) begin
                highs++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (first !== SERVE_LAT) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, first, SERVE_LAT); end
        checks++;
        if (highs !== 1) begin errors++; $display("FAIL %s_pulse_count: got %0d expected 1", name, highs); end
        srv_btn = 1'b0;
        ticks(10);
    endtask

    task automatic test_serve();
        ticks(10);
        serve_window("serve_first", 100);
        serve_window("serve_second", 30);
    endtask

    task automatic test_idle();
        int highs;
        multi = 1'b1;
        up1 = 1'b1;
        ticks(10);
        for (int f = 0; f < 3; f++) begin
            frame();
            m_pos1 = human_model(m_pos1, 1'b1, 1'b0);
        end
        checks++;
        if (pos1 !== 10'(m_pos1)) begin errors++; $display("FAIL idle_premove: got %0d expected %0d", pos1, m_pos1); end
        idle = 1'b1;
        srv_btn = 1'b1;
        tick();
        m_pos1 = CENTRE;
        m_pos2 = CENTRE;
        checks++;
        if (pos1 !== 10'(CENTRE) || pos2 !== 10'(CENTRE)) begin
            errors++;
            $display("FAIL idle_load: got %0d/%0d expected %0d/%0d", pos1, pos2, CENTRE, CENTRE);
        end
        for (int i = 0; i < 20; i++) begin
            eof = (i % 3 == 0);
            tick();
            checks++;
            if (pos1 !== 10'(CENTRE) || serve !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got pos %0d serve %0b expected %0d serve 0", i, pos1, serve, CENTRE);
            end
        end
        eof = 1'b0;
        up1 = 1'b0;
        idle = 1'b0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (serve === 1'b1) highs++;
        end
        checks++;
        if (highs !== 0) begin errors++; $display("FAIL idle_exit_held: got %0d pulses expected 0", highs); end
        srv_btn = 1'b0;
        ticks(10);
        serve_window("serve_after_idle", 20);
    endtask

    task automatic test_random();
        bit r_up1, r_dn1, r_up2, r_dn2, r_multi;
        int r_ball;
        for (int it = 0; it < 40; it++) begin
            r_up1 = 1'($urandom);
            r_dn1 = 1'($urandom);
            r_up2 = 1'($urandom);
            r_dn2 = 1'($urandom);
            r_multi = 1'($urandom);
            r_ball = $urandom_range(0, 2047);
            up1 = r_up1; dn1 = r_dn1; up2 = r_up2; dn2 = r_dn2;
            multi = r_multi;
            ball = 11'(r_ball);
            ticks(8 + $urandom_range(0, 4));
            for (int f = 0; f < 1 + $urandom_range(0, 3); f++) begin
                frame();
                m_pos1 = human_model(m_pos1, r_up1, r_dn1);
                m_pos2 = r_multi ? human_model(m_pos2, r_up2, r_dn2) : ai_model(m_pos2, r_ball);
                checks++;
                if (pos1 !== 10'(m_pos1) || pos2 !== 10'(m_pos2)) begin
                    errors++;
                    $display("FAIL random it %0d: got %0d/%0d expected %0d/%0d", it, pos1, pos2, m_pos1, m_pos2);
                end
                tick();
            end
        end
        up1 = 1'b0; dn1 = 1'b0; up2 = 1'b0; dn2 = 1'b0;
        ticks(10);
    endtask

    task automatic test_rst_mid();
        multi = 1'b1;
        dn1 = 1'b1;
        ticks(10);
        for (int f = 0; f < 3; f++) begin
            frame();
            m_pos1 = human_model(m_pos1, 1'b0, 1'b1);
        end
        checks++;
        if (pos1 !== 10'(m_pos1)) begin errors++; $display("FAIL rst_premove: got %0d expected %0d", pos1, m_pos1); end
        rst = 1'b1;
        tick();
        m_pos1 = CENTRE;
        m_pos2 = CENTRE;
        checks++;
        if (pos1 !== 10'(CENTRE) || pos2 !== 10'(CENTRE) || serve !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got %0d/%0d serve %0b expected %0d/%0d serve 0", pos1, pos2, serve, CENTRE, CENTRE);
        end
        rst = 1'b0;
        tick();
        frame();
        checks++;
        if (pos1 !== 10'(CENTRE)) begin errors++; $display("FAIL rst_debounce_cleared: got %0d expected %0d", pos1, CENTRE); end
        ticks(10);
        frame();
        m_pos1 = human_model(m_pos1, 1'b0, 1'b1);
        checks++;
        if (pos1 !== 10'(m_pos1)) begin errors++; $display("FAIL rst_resume: got %0d expected %0d", pos1, m_pos1); end
        dn1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; eof = 1'b0;
        up1 = 1'b0; dn1 = 1'b0; up2 = 1'b0; dn2 = 1'b0; srv_btn = 1'b0;
        idle = 1'b0; multi = 1'b1; ball = '0;
        test_reset();
        test_human();
        test_both_and_glitch();
        test_ai();
        test_serve();
        test_idle();
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
